// File: rtl/uart_cmd_rx.sv
// uart_cmd_rx: 8N1 UART receiver plus framed-command parser for the scope capture configuration.
// Latency: rx_byte_valid at the stop-bit sample point; config update and cmd_ok 1 clk after the last byte.
// Backpressure: none; the serial line cannot be stalled, so every byte is consumed as it arrives.
//
// Optional build macro: CMD_CHECKSUM_EN
//   defined     -> 4-byte frame SYNC,CMD,DATA,SUM with SUM = (CMD+DATA) mod 256
//   not defined -> 3-byte frame SYNC,CMD,DATA
//
// Ports:
//   clk, rst                   system clock (27 MHz) and asynchronous active-high reset
//   uart_rx                    serial input, idle high, asynchronous to clk
//   rx_byte / rx_byte_valid    last good byte and its 1-clk strobe
//   frame_err                  1-clk pulse when the stop bit samples low
//   cfg_rate, cfg_trig_level   8-bit capture settings
//   cfg_run, cfg_trig_edge     run enable and trigger edge (0 rising, 1 falling)
//   arm_pulse                  1-clk arm strobe, coincident with cmd_ok
//   cmd_ok / cmd_err           1-clk command applied / command rejected or timed out
module uart_cmd_rx #(
  parameter int         DELAY_FRAMES = 234,
  parameter int         TIMEOUT_CLKS = 270000,
  parameter logic [7:0] SYNC_BYTE    = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_rx,
  output logic [7:0] rx_byte,
  output logic       rx_byte_valid,
  output logic       frame_err,
  output logic [7:0] cfg_rate,
  output logic [7:0] cfg_trig_level,
  output logic       cfg_run,
  output logic       cfg_trig_edge,
  output logic       arm_pulse,
  output logic       cmd_ok,
  output logic       cmd_err
);

  localparam int CW = $clog2(DELAY_FRAMES);
  localparam int TW = $clog2(TIMEOUT_CLKS);
  localparam logic [CW-1:0] BIT_LAST  = CW'(DELAY_FRAMES - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(DELAY_FRAMES / 2 - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CLKS - 1);

  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  localparam logic [1:0] P_SYNC = 2'd0;
  localparam logic [1:0] P_CMD  = 2'd1;
  localparam logic [1:0] P_DATA = 2'd2;
`ifdef CMD_CHECKSUM_EN
  localparam logic [1:0] P_SUM  = 2'd3;
`endif

  // ---------------- UART receiver ----------------
  logic          r_rx_s1;
  logic          r_rx_s2;
  logic          r_rx_prev;
  logic [1:0]    r_rx_state;
  logic [CW-1:0] r_clk_cnt;
  logic [2:0]    r_bit_idx;
  logic [7:0]    r_shift;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_s1       <= 1'b1;
      r_rx_s2       <= 1'b1;
      r_rx_prev     <= 1'b1;
      r_rx_state    <= RX_IDLE;
      r_clk_cnt     <= '0;
      r_bit_idx     <= '0;
      r_shift       <= '0;
      rx_byte       <= '0;
      rx_byte_valid <= 1'b0;
      frame_err     <= 1'b0;
    end else begin
      r_rx_s1       <= uart_rx;
      r_rx_s2       <= r_rx_s1;
      r_rx_prev     <= r_rx_s2;
      rx_byte_valid <= 1'b0;
      frame_err     <= 1'b0;
      case (r_rx_state)
        RX_IDLE: begin
          r_clk_cnt <= '0;
          r_bit_idx <= '0;
          // Edge-triggered start: a line stuck low has prev=0 and cannot retrigger.
          if (r_rx_prev && !r_rx_s2) r_rx_state <= RX_START;
        end
        RX_START: begin
          if (r_clk_cnt == HALF_LAST) begin
            // Mid start bit: high again means it was a glitch.
            r_clk_cnt  <= '0;
            r_rx_state <= r_rx_s2 ? RX_IDLE : RX_DATA;
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (r_clk_cnt == BIT_LAST) begin
            r_clk_cnt <= '0;
            r_shift   <= {r_rx_s2, r_shift[7:1]};
            r_bit_idx <= r_bit_idx + 1'b1;
            if (r_bit_idx == 3'd7) r_rx_state <= RX_STOP;
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (r_clk_cnt == BIT_LAST) begin
            r_clk_cnt  <= '0;
            r_rx_state <= RX_IDLE;
            if (r_rx_s2) begin
              rx_byte       <= r_shift;
              rx_byte_valid <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
        default: r_rx_state <= RX_IDLE;
      endcase
    end
  end

  // ---------------- Command parser ----------------
  logic [1:0]    r_p_state;
  logic [7:0]    r_cmd;
  logic [TW-1:0] r_to_cnt;
`ifdef CMD_CHECKSUM_EN
  logic [7:0]    r_data;
  logic [7:0]    w_sum;
  assign w_sum = r_cmd + r_data;
`endif

  logic       w_final;
  logic       w_sum_bad;
  logic       w_known;
  logic [7:0] w_exec_data;

  // w_final marks the byte that completes a frame; execution lands on the next edge.
  always_comb begin
    w_final     = 1'b0;
    w_sum_bad   = 1'b0;
    w_exec_data = rx_byte;
`ifdef CMD_CHECKSUM_EN
    w_final     = rx_byte_valid && (r_p_state == P_SUM);
    w_sum_bad   = (rx_byte != w_sum);
    w_exec_data = r_data;
`else
    w_final     = rx_byte_valid && (r_p_state == P_DATA);
`endif
  end

  assign w_known = (r_cmd == 8'h01) || (r_cmd == 8'h02) || (r_cmd == 8'h03) || (r_cmd == 8'h04);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_p_state      <= P_SYNC;
      r_cmd          <= '0;
`ifdef CMD_CHECKSUM_EN
      r_data         <= '0;
`endif
      r_to_cnt       <= '0;
      cfg_rate       <= 8'h64;
      cfg_trig_level <= 8'h80;
      cfg_run        <= 1'b0;
      cfg_trig_edge  <= 1'b0;
      arm_pulse      <= 1'b0;
      cmd_ok         <= 1'b0;
      cmd_err        <= 1'b0;
    end else begin
      arm_pulse <= 1'b0;
      cmd_ok    <= 1'b0;
      cmd_err   <= 1'b0;

      // A byte beats a coincident timeout; frame_err aborts silently.
      if (rx_byte_valid) begin
        r_to_cnt <= '0;
        case (r_p_state)
          P_SYNC: if (rx_byte == SYNC_BYTE) r_p_state <= P_CMD;
          P_CMD: begin
            r_cmd     <= rx_byte;
            r_p_state <= P_DATA;
          end
`ifdef CMD_CHECKSUM_EN
          P_DATA: begin
            r_data    <= rx_byte;
            r_p_state <= P_SUM;
          end
`endif
          default: r_p_state <= P_SYNC;
        endcase
      end else if (frame_err) begin
        r_to_cnt  <= '0;
        r_p_state <= P_SYNC;
      end else if (r_p_state != P_SYNC) begin
        if (r_to_cnt == TO_LAST) begin
          r_to_cnt  <= '0;
          r_p_state <= P_SYNC;
          cmd_err   <= 1'b1;
        end else begin
          r_to_cnt <= r_to_cnt + 1'b1;
        end
      end else begin
        r_to_cnt <= '0;
      end

      if (w_final) begin
        if (w_sum_bad || !w_known) begin
          cmd_err <= 1'b1;
        end else begin
          cmd_ok <= 1'b1;
          case (r_cmd)
            8'h01: cfg_rate       <= w_exec_data;
            8'h02: cfg_trig_level <= w_exec_data;
            8'h03: begin
              cfg_run       <= w_exec_data[0];
              cfg_trig_edge <= w_exec_data[1];
            end
            default: arm_pulse <= 1'b1;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_rx.sv
module tb_uart_cmd_rx;

  localparam int DF = 16;
  localparam int TO = 1500;
  localparam logic [7:0] SYNC = 8'hA5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       uart_rx = 1'b1;
  logic [7:0] rx_byte;
  logic       rx_byte_valid;
  logic       frame_err;
  logic [7:0] cfg_rate;
  logic [7:0] cfg_trig_level;
  logic       cfg_run;
  logic       cfg_trig_edge;
  logic       arm_pulse;
  logic       cmd_ok;
  logic       cmd_err;

  uart_cmd_rx #(.DELAY_FRAMES(DF), .TIMEOUT_CLKS(TO), .SYNC_BYTE(SYNC)) dut (
    .clk(clk), .rst(rst), .uart_rx(uart_rx),
    .rx_byte(rx_byte), .rx_byte_valid(rx_byte_valid), .frame_err(frame_err),
    .cfg_rate(cfg_rate), .cfg_trig_level(cfg_trig_level), .cfg_run(cfg_run),
    .cfg_trig_edge(cfg_trig_edge), .arm_pulse(arm_pulse), .cmd_ok(cmd_ok), .cmd_err(cmd_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc = 0;
  int cnt_valid = 0, cnt_ferr = 0, cnt_ok = 0, cnt_err = 0, cnt_arm = 0;
  int last_valid_cyc = 0, last_ok_cyc = 0, last_err_cyc = 0;
  logic [7:0] exp_q[$];

  always @(posedge clk) cyc++;

  // Scoreboard: every good byte must match the oldest byte pushed by the sender.
  always @(negedge clk) begin
    if (!rst) begin
      if (rx_byte_valid) begin
        cnt_valid++;
        last_valid_cyc = cyc;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL sb_unexpected_byte got=%02h expected=none", rx_byte);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          if (rx_byte !== e) begin
            n_fail++;
            $display("FAIL sb_byte got=%02h expected=%02h", rx_byte, e);
          end
        end
      end
      if (frame_err) cnt_ferr++;
      if (cmd_ok) begin cnt_ok++; last_ok_cyc = cyc; end
      if (cmd_err) begin cnt_err++; last_err_cyc = cyc; end
      if (arm_pulse) begin
        cnt_arm++;
        n_checks++;
        if (cmd_ok !== 1'b1) begin
          n_fail++;
          $display("FAIL arm_with_cmd_ok cmd_ok=%b expected=1", cmd_ok);
        end
      end
    end
  end

  task automatic send_bit(input logic v);
    uart_rx = v;
    repeat (DF) @(posedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop);
    uart_rx = 1'b1;
  endtask

  task automatic put(input logic [7:0] b);
    exp_q.push_back(b);
    send_byte(b, 1'b1);
  endtask

  task automatic send_frame(input logic [7:0] cmd, input logic [7:0] data);
    logic [7:0] s;
    s = cmd + data;
    put(SYNC);
    put(cmd);
    put(data);
`ifdef CMD_CHECKSUM_EN
    put(s);
`endif
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    logic [30:0] got, exp;
    rst = 1'b1;
    uart_rx = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    got = {rx_byte, cfg_rate, cfg_trig_level, cfg_run, cfg_trig_edge,
           rx_byte_valid, frame_err, cmd_ok, cmd_err, arm_pulse};
    exp = {8'h00, 8'h64, 8'h80, 7'b0};
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL reset_values got=%08h expected=%08h", got, exp);
    end
    rst = 1'b0;
    repeat (2 * DF) @(posedge clk);
  endtask

  task automatic test_byte;
    int v0, f0;
    v0 = cnt_valid; f0 = cnt_ferr;
    put(8'h5A);
    repeat (DF) @(posedge clk);
    #1;
    n_checks++;
    if (cnt_valid - v0 != 1) begin n_fail++; $display("FAIL t1_valid_count got=%0d expected=1", cnt_valid - v0); end
    n_checks++;
    if (cnt_ferr != f0) begin n_fail++; $display("FAIL t1_frame_err got=%0d expected=0", cnt_ferr - f0); end
  endtask

  task automatic test_trig_level;
    int o0;
    o0 = cnt_ok;
    send_frame(8'h02, 8'h40);
    n_checks++;
    if (cfg_trig_level !== 8'h40) begin n_fail++; $display("FAIL t2_trig_level got=%02h expected=40", cfg_trig_level); end
    n_checks++;
    if (cnt_ok - o0 != 1) begin n_fail++; $display("FAIL t2_cmd_ok_count got=%0d expected=1", cnt_ok - o0); end
    n_checks++;
    if (last_ok_cyc - last_valid_cyc != 1) begin
      n_fail++;
      $display("FAIL t2_cmd_ok_latency got=%0d expected=1", last_ok_cyc - last_valid_cyc);
    end
  endtask

  task automatic test_run_arm;
    int a0;
    send_frame(8'h03, 8'h03);
    n_checks++;
    if ({cfg_run, cfg_trig_edge} !== 2'b11) begin n_fail++; $display("FAIL t3_run_edge got=%b%b expected=11", cfg_run, cfg_trig_edge); end
    a0 = cnt_arm;
    send_frame(8'h04, 8'h00);
    n_checks++;
    if (cnt_arm - a0 != 1) begin n_fail++; $display("FAIL t3_arm_count got=%0d expected=1", cnt_arm - a0); end
    n_checks++;
    if (cfg_run !== 1'b1) begin n_fail++; $display("FAIL t3_run_kept got=%b expected=1", cfg_run); end
    send_frame(8'h03, 8'hFD);
    n_checks++;
    if ({cfg_run, cfg_trig_edge} !== 2'b10) begin n_fail++; $display("FAIL t3_upper_bits_ignored got=%b%b expected=10", cfg_run, cfg_trig_edge); end
  endtask

  task automatic test_errors;
    int e0, o0;
`ifdef CMD_CHECKSUM_EN
    e0 = cnt_err; o0 = cnt_ok;
    put(SYNC); put(8'h01); put(8'h10); put(8'hFF);
    repeat (4) @(posedge clk);
    #1;
    n_checks++;
    if (cnt_err - e0 != 1 || cnt_ok != o0) begin
      n_fail++;
      $display("FAIL t4_bad_sum err=%0d ok=%0d expected err=1 ok=0", cnt_err - e0, cnt_ok - o0);
    end
    n_checks++;
    if (cfg_rate !== 8'h64) begin n_fail++; $display("FAIL t4_rate_kept got=%02h expected=64", cfg_rate); end
`endif
    e0 = cnt_err; o0 = cnt_ok;
    send_frame(8'h07, 8'h00);
    n_checks++;
    if (cnt_err - e0 != 1 || cnt_ok != o0) begin
      n_fail++;
      $display("FAIL t4_unknown_cmd err=%0d ok=%0d expected err=1 ok=0", cnt_err - e0, cnt_ok - o0);
    end
    // A sync value inside the frame is plain data.
    send_frame(8'h01, SYNC);
    n_checks++;
    if (cfg_rate !== SYNC) begin n_fail++; $display("FAIL t4_sync_as_data got=%02h expected=%02h", cfg_rate, SYNC); end
  endtask

  task automatic test_back_to_back;
    int e0, o0;
    e0 = cnt_err; o0 = cnt_ok;
    put(8'h5A);
    put(SYNC); put(8'h02); put(8'h11);
`ifdef CMD_CHECKSUM_EN
    put(8'h13);
`endif
    send_frame(8'h01, 8'h33);
    n_checks++;
    if (cnt_ok - o0 != 2 || cnt_err != e0) begin
      n_fail++;
      $display("FAIL b2b_counts ok=%0d err=%0d expected ok=2 err=0", cnt_ok - o0, cnt_err - e0);
    end
    n_checks++;
    if ({cfg_trig_level, cfg_rate} !== 16'h1133) begin
      n_fail++;
      $display("FAIL b2b_regs got=%04h expected=1133", {cfg_trig_level, cfg_rate});
    end
  endtask

  task automatic test_timeout;
    int e0, o0, d;
    e0 = cnt_err; o0 = cnt_ok;
    put(SYNC); put(8'h01);
    for (int i = 0; i < TO + 200 && cnt_err == e0; i++) @(posedge clk);
    #1;
    n_checks++;
    if (cnt_err - e0 != 1) begin
      n_fail++;
      $display("FAIL t5_timeout_err got=%0d expected=1", cnt_err - e0);
    end else begin
      d = last_err_cyc - last_valid_cyc;
      n_checks++;
      if (d < TO || d > TO + 2) begin n_fail++; $display("FAIL t5_timeout_delay got=%0d expected=%0d..%0d", d, TO, TO + 2); end
    end
    n_checks++;
    if (cnt_ok != o0 || cfg_rate !== 8'h33) begin
      n_fail++;
      $display("FAIL t5_no_apply ok=%0d rate=%02h expected ok=0 rate=33", cnt_ok - o0, cfg_rate);
    end
    send_frame(8'h01, 8'h22);
    n_checks++;
    if (cfg_rate !== 8'h22) begin n_fail++; $display("FAIL t5_recover got=%02h expected=22", cfg_rate); end
  endtask

  task automatic test_line_faults;
    int v0, f0, e0, o0;
    v0 = cnt_valid; f0 = cnt_ferr;
    send_byte(8'h3C, 1'b0);
    uart_rx = 1'b0;
    repeat (3 * DF) @(posedge clk);
    uart_rx = 1'b1;
    repeat (2 * DF) @(posedge clk);
    #1;
    n_checks++;
    if (cnt_ferr - f0 != 1 || cnt_valid != v0) begin
      n_fail++;
      $display("FAIL t6_stop_low ferr=%0d valid=%0d expected ferr=1 valid=0", cnt_ferr - f0, cnt_valid - v0);
    end
    v0 = cnt_valid; f0 = cnt_ferr;
    uart_rx = 1'b0;
    repeat (4) @(posedge clk);
    uart_rx = 1'b1;
    repeat (12 * DF) @(posedge clk);
    #1;
    n_checks++;
    if (cnt_ferr != f0 || cnt_valid != v0) begin
      n_fail++;
      $display("FAIL t6_glitch ferr=%0d valid=%0d expected 0 0", cnt_ferr - f0, cnt_valid - v0);
    end
    // frame_err mid-frame drops the frame without cmd_err; the tail bytes are ignored.
    e0 = cnt_err; o0 = cnt_ok;
    put(SYNC);
    send_byte(8'h77, 1'b0);
    repeat (2 * DF) @(posedge clk);
    put(8'h03); put(8'h02); put(8'h05);
    repeat (4) @(posedge clk);
    #1;
    n_checks++;
    if (cnt_err != e0 || cnt_ok != o0 || cfg_trig_edge !== 1'b0) begin
      n_fail++;
      $display("FAIL t6_ferr_midframe err=%0d ok=%0d edge=%b expected 0 0 0", cnt_err - e0, cnt_ok - o0, cfg_trig_edge);
    end
  endtask

  task automatic test_rst_mid_byte;
    logic [30:0] got, exp;
    int v0;
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    repeat (DF / 2) @(posedge clk);
    rst = 1'b1;
    uart_rx = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    got = {rx_byte, cfg_rate, cfg_trig_level, cfg_run, cfg_trig_edge,
           rx_byte_valid, frame_err, cmd_ok, cmd_err, arm_pulse};
    exp = {8'h00, 8'h64, 8'h80, 7'b0};
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL t6_rst_mid_byte got=%08h expected=%08h", got, exp);
    end
    rst = 1'b0;
    repeat (2 * DF) @(posedge clk);
    v0 = cnt_valid;
    put(8'hC3);
    repeat (DF) @(posedge clk);
    #1;
    n_checks++;
    if (cnt_valid - v0 != 1) begin n_fail++; $display("FAIL t6_after_rst_valid got=%0d expected=1", cnt_valid - v0); end
  endtask

  initial begin
    test_reset();
    test_byte();
    test_trig_level();
    test_run_arm();
    test_errors();
    test_back_to_back();
    test_timeout();
    test_line_faults();
    test_rst_mid_byte();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_leftover got=%0d expected=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
